// File: rtl/_w5300_parallel_if_burst_pkg.sv
// Shared types, default bus timing and parameter legality helpers
// for the W5300 parallel-bus burst engine.
package w5300_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WR,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam int unsigned T_SETUP_DEF   = 1;
    localparam int unsigned T_STROBE_DEF  = 7;
    localparam int unsigned T_HOLD_DEF    = 1;
    localparam int unsigned T_RECOVER_DEF = 3;

    function automatic bit params_legal(input int unsigned data_w,
                                        input int unsigned t_setup,
                                        input int unsigned t_strobe,
                                        input int unsigned t_hold,
                                        input int unsigned t_recover);
        return ((data_w == 8) || (data_w == 16)) &&
               (t_setup >= 1) && (t_strobe >= 1) &&
               (t_hold >= 1) && (t_recover >= 1);
    endfunction

    function automatic int unsigned max_timing(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c,
                                               input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/_w5300_parallel_if_burst_phase_timer.sv
// Loadable down-counter shared by all timed bus phases; tc is high
// during the last cycle of the loaded phase length.
module _w5300_phase_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/_w5300_parallel_if_burst.sv
// W5300 host-bus read/write engine with single or burst accesses,
// programmable setup/strobe/hold/recovery and optional address increment.
module _w5300_parallel_if_burst
    import w5300_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned T_SETUP   = T_SETUP_DEF,
    parameter int unsigned T_STROBE  = T_STROBE_DEF,
    parameter int unsigned T_HOLD    = T_HOLD_DEF,
    parameter int unsigned T_RECOVER = T_RECOVER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              cs_n,
    output logic              rd_n,
    output logic              we_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_incr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done
);

    localparam int unsigned T_MAX = max_timing(T_SETUP, T_STROBE, T_HOLD, T_RECOVER);
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    if (!params_legal(DATA_W, T_SETUP, T_STROBE, T_HOLD, T_RECOVER)) begin : g_illegal
        $error("_w5300_parallel_if_burst: illegal DATA_W or timing parameter");
    end

    state_t            state, next_state;
    logic              wr_q, incr_q, oe_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dout_q;
    logic              tc, load, last_beat, beat_write, wr_take;
    logic [TW-1:0]     load_val;
    logic              cs_n_d, rd_n_d, we_n_d, oe_d;

    assign last_beat  = (cnt_q == '0);
    assign beat_write = (state == ST_IDLE) ? req_write : wr_q;

    _w5300_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // WAIT_WR is only entered when write data is missing; otherwise the word
    // is latched on the way into SETUP so write beats keep the read cadence.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (req_valid) next_state = (req_write && !wr_valid) ? ST_WAIT_WR : ST_SETUP;
            ST_WAIT_WR: if (wr_valid) next_state = ST_SETUP;
            ST_SETUP:   if (tc) next_state = ST_STROBE;
            ST_STROBE:  if (tc) next_state = ST_HOLD;
            ST_HOLD:    if (tc) next_state = ST_RECOVER;
            ST_RECOVER: begin
                if (tc) begin
                    if (last_beat)            next_state = ST_IDLE;
                    else if (wr_q && !wr_valid) next_state = ST_WAIT_WR;
                    else                      next_state = ST_SETUP;
                end
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = (next_state != state);
        load_val = '0;
        wr_take  = beat_write && (next_state == ST_SETUP) &&
                   (state inside {ST_IDLE, ST_WAIT_WR, ST_RECOVER});
        unique case (next_state)
            ST_SETUP:   load_val = TW'(T_SETUP - 1);
            ST_STROBE:  load_val = TW'(T_STROBE - 1);
            ST_HOLD:    load_val = TW'(T_HOLD - 1);
            ST_RECOVER: load_val = TW'(T_RECOVER - 1);
            default:    load_val = '0;
        endcase
        cs_n_d = !(next_state inside {ST_SETUP, ST_STROBE, ST_HOLD});
        rd_n_d = !((next_state == ST_STROBE) && !beat_write);
        we_n_d = !((next_state == ST_STROBE) && beat_write);
        oe_d   = !cs_n_d && beat_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            incr_q    <= 1'b0;
            cnt_q     <= '0;
            addr      <= '0;
            dout_q    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            we_n      <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && req_valid) begin
                wr_q   <= req_write;
                incr_q <= req_incr;
                cnt_q  <= req_len;
                addr   <= req_addr;
            end else if ((state == ST_RECOVER) && tc && !last_beat) begin
                cnt_q <= cnt_q - LEN_W'(1);
                addr  <= addr + ADDR_W'(incr_q);
            end
            if (wr_take) dout_q <= wr_data;
            if ((state == ST_STROBE) && tc && !wr_q) rd_data <= data;
            rd_valid  <= (state == ST_STROBE) && tc && !wr_q;
            wr_ready  <= wr_take;
            done      <= (state == ST_RECOVER) && tc && last_beat;
            req_ready <= (next_state == ST_IDLE);
            cs_n      <= cs_n_d;
            rd_n      <= rd_n_d;
            we_n      <= we_n_d;
            oe_q      <= oe_d;
        end
    end

    assign data = oe_q ? dout_q : 'z;

endmodule
